// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: FSM state encodings and phase-step helper for pulse_sequencer.
package pulse_seq_pkg;

    localparam logic [1:0] ST_ISSUE      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_START_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR        = 2'd3;

    function automatic int next_phase(input int p, input int n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/pulse_timeout_counter.sv
// pulse_timeout_counter: saturating wait counter; expired flags the last allowed wait cycle.
module pulse_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (TIMEOUT_CYCLES > 0) && i_enable && (r_cnt == LIM);

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: phase distributor stepping 0..N_PHASE-1 with per-phase
// mem-read / start-wait masks, read timeout, single-step and halt.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int N_PHASE        = 8,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int PW            = $clog2(N_PHASE)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_pulse_from_io,
    input  logic               mem_read_reply_from_mem,
    input  logic [N_PHASE-1:0] wait_start_mask_from_op,
    input  logic [N_PHASE-1:0] mem_read_mask_from_op,
    input  logic               step_mode_from_io,
    input  logic               halt_from_io,
    input  logic               clear_err_from_io,
    output logic [PW-1:0]      cur_pulse,
    output logic [N_PHASE-1:0] at_pulse,
    output logic [N_PHASE-1:0] entering_pulse,
    output logic               mem_read_to_mem,
    output logic [N_PHASE-1:0] mem_reply_at_pulse,
    output logic               operate_pulse_to_op,
    output logic               timeout_err
);
    localparam logic [N_PHASE-1:0] ONE = N_PHASE'(1);

    logic [1:0]         r_state;
    logic [PW-1:0]      r_cur;
    logic               r_hold;
    logic [N_PHASE-1:0] w_ws;
    logic               w_ws_p;
    logic               w_mr_p;
    logic [PW-1:0]      w_nxt;
    logic               w_req;
    logic               w_reply;
    logic               w_adv;
    logic               w_expired;

    assign w_ws    = wait_start_mask_from_op | N_PHASE'(step_mode_from_io);
    assign w_ws_p  = w_ws[r_cur];
    assign w_mr_p  = mem_read_mask_from_op[r_cur];
    assign w_nxt   = PW'(next_phase(int'(r_cur), N_PHASE));
    assign w_req   = resetn && (r_state == ST_ISSUE) && w_mr_p;
    assign w_reply = resetn && (r_state == ST_MEM_WAIT) && mem_read_reply_from_mem;

    // r_hold marks a START_WAIT entered only because halt blocked a finished read
    always_comb
        w_adv = resetn && !halt_from_io && (
                (r_state == ST_ISSUE)      ? (!w_mr_p && !w_ws_p) :
                (r_state == ST_MEM_WAIT)   ? (w_reply && !w_ws_p) :
                (r_state == ST_START_WAIT) ? (r_hold || start_pulse_from_io) : 1'b0);

    pulse_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk      (clk),
        .resetn   (resetn),
        .i_clear  (w_req),
        .i_enable (r_state == ST_MEM_WAIT),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_ISSUE;
            r_cur   <= '0;
            r_hold  <= 1'b0;
        end else if (w_adv) begin
            r_state <= ST_ISSUE;
            r_cur   <= w_nxt;
            r_hold  <= 1'b0;
        end else begin
            case (r_state)
                ST_ISSUE:
                    r_state <= w_mr_p ? ST_MEM_WAIT : w_ws_p ? ST_START_WAIT : ST_ISSUE;
                ST_MEM_WAIT:
                    if (w_reply) begin
                        r_state <= ST_START_WAIT;
                        r_hold  <= !w_ws_p;
                    end else if (w_expired) begin
                        r_state <= ST_ERR;
                    end
                ST_ERR:
                    if (clear_err_from_io) begin
                        r_state <= ST_ISSUE;
                        r_cur   <= '0;
                    end
                default: ;
            endcase
        end
    end

    assign cur_pulse           = r_cur;
    assign at_pulse            = ONE << r_cur;
    assign entering_pulse      = w_adv ? (ONE << w_nxt) : '0;
    assign mem_read_to_mem     = w_req;
    assign mem_reply_at_pulse  = w_reply ? (ONE << r_cur) : '0;
    assign operate_pulse_to_op = w_adv && (r_cur == PW'(N_PHASE - 1));
    assign timeout_err         = r_state == ST_ERR;

endmodule
